re_log_accum: RTL and testbench
===============================

RE_LOG_ACCUM -- requirements
Module: re_log_accum

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 16, number of accepted input beats per frame (legal 1..65535).
REQ-002 SHALL have parameter ACC_W, default 40, accumulator/output width (legal `NUM_LENGTH+1..64).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream beat valid.
REQ-006 SHALL have port in_data  input  `NUM_LENGTH  remapped {k, m2} word from the remap datapath, treated as unsigned.
REQ-007 SHALL have port in_ready  output  1  beat accepted when in_valid and in_ready are both high.
REQ-008 SHALL have port clr  input  1  synchronous frame abort.
REQ-009 SHALL have port out_valid  output  1  frame result available.
REQ-010 SHALL have port out_ready  input  1  downstream accepts result when out_valid and out_ready are both high.
REQ-011 SHALL have port out_sum  output  ACC_W  unsigned frame sum of in_data.
REQ-012 SHALL have port out_ovf  output  1  frame sum exceeded 2^ACC_W-1.

Function
REQ-013 SHALL implement states IDLE, ACC, OUT.
REQ-014 IDLE: in_ready=1, out_valid=0; on an accepted beat, acc=in_data, cnt=1, next state OUT if FRAME_LEN==1, else ACC.
REQ-015 ACC: in_ready=1; on an accepted beat, acc=acc+in_data, cnt=cnt+1; when the new cnt equals FRAME_LEN, next state OUT.
REQ-016 No accepted beat (in_valid=0): acc, cnt, and state SHALL hold; gaps of any length are legal.
REQ-017 OUT: in_ready=0, out_valid=1; out_sum/out_ovf stable until the handshake; on out_ready=1, next state IDLE with acc=0, cnt=0, ovf=0.
REQ-018 Latency: out_valid SHALL rise on the clock edge that accepts the FRAME_LEN-th beat, i.e. visible one cycle after that beat is presented.
REQ-019 out_sum SHALL be driven directly from the acc register; it is meaningful only while out_valid=1.
REQ-020 Addition SHALL zero-extend in_data to ACC_W+1 bits; carry-out sets the sticky ovf register for the current frame.
REQ-021 clr=1 SHALL take priority over all handshakes: next state IDLE, acc=0, cnt=0, ovf=0, and any beat or result handshake in that cycle is discarded.
REQ-022 No beat SHALL be accepted in the same cycle the result handshake completes; the next frame starts in IDLE.

Reset
REQ-023 While rst=1, regardless of clk: state=IDLE, acc=0, cnt=0, ovf=0, so in_ready=1, out_valid=0, out_sum=0, out_ovf=0.
REQ-024 Reset asserted mid-frame or in OUT SHALL discard the partial/pending frame; first edge after deassertion behaves as IDLE.

Configuration
REQ-025 Macro RE_ACC_SAT_EN defined: on carry-out acc SHALL clamp to 2^ACC_W-1 and stay clamped for the rest of the frame; out_ovf reports ovf.
REQ-026 RE_ACC_SAT_EN undefined: acc SHALL wrap modulo 2^ACC_W; out_ovf SHALL be tied to 0 and no ovf register exists.

Verification
REQ-027 FRAME_LEN=4, beats 1,2,3,4 on consecutive cycles, out_ready=1 -> out_valid for exactly one cycle, out_sum=10, one cycle after beat 4; then in_ready=1.
REQ-028 FRAME_LEN=4, beats 5,0,7,9 with 2-cycle in_valid gaps between them, out_ready held 0 for 5 cycles -> out_sum=21 held stable, in_ready=0 throughout OUT, IDLE after out_ready rises.
REQ-029 FRAME_LEN=4, two beats of 100, then clr pulse, then beats 1,1,1,1 -> out_sum=4 (aborted data absent).
REQ-030 ACC_W=33, FRAME_LEN=4, four beats 0xFFFFFFFF -> with RE_ACC_SAT_EN: out_sum=0x1FFFFFFFF, out_ovf=1; without: out_sum=0x1FFFFFFFC, out_ovf=0.
REQ-031 rst asserted asynchronously between clock edges after beat 3 of 4 -> outputs immediately at reset values; a fresh frame 2,2,2,2 after release -> out_sum=8.
REQ-032 FRAME_LEN=1, beats 7 and 9 presented continuously, out_ready=1 -> results 7 and 9, each in_data accepted only from IDLE (one beat per two cycles).

Source files
------------

// File: rtl/re_log_accum.sv
// re_log_accum: frame accumulator for remapped {k, m2} words.
// Sums FRAME_LEN accepted beats, then holds the sum until the result handshake.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid, in_data     upstream beat (unsigned `NUM_LENGTH bits)
//   in_ready              high in IDLE/ACC, low while a result is pending
//   clr                   synchronous frame abort, overrides all handshakes
//   out_valid, out_ready  result handshake
//   out_sum, out_ovf      frame sum and sticky overflow flag
//
// Optional feature: define RE_ACC_SAT_EN to saturate the sum at 2^ACC_W-1
// and report overflow on out_ovf; otherwise the sum wraps and out_ovf is 0.

`ifndef NUM_LENGTH
`define NUM_LENGTH 32
`endif

module re_log_accum #(
   parameter int FRAME_LEN = 16,
   parameter int ACC_W     = 40
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [`NUM_LENGTH-1:0] in_data,
   output logic                   in_ready,
   input  logic                   clr,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ACC_W-1:0]       out_sum,
   output logic                   out_ovf
);

   localparam int          NL = `NUM_LENGTH;
   localparam logic [15:0] FL = 16'(FRAME_LEN);

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      OUT
   } state_t;

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [15:0]      cnt;
   logic [15:0]      cnt_nxt;
   logic [ACC_W:0]   sum;

`ifdef RE_ACC_SAT_EN
   logic ovf;
`else
   logic unused_carry;
`endif

   // Handshake outputs decode straight from the state register.
   assign in_ready  = (state != OUT);
   assign out_valid = (state == OUT);
   assign out_sum   = acc;

   // One extra bit so the carry-out of the frame sum is visible.
   assign sum     = {1'b0, acc} + {{(ACC_W + 1 - NL){1'b0}}, in_data};
   assign cnt_nxt = cnt + 16'd1;

`ifdef RE_ACC_SAT_EN
   assign out_ovf = ovf;
`else
   assign out_ovf      = 1'b0;
   assign unused_carry = sum[ACC_W];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         cnt   <= '0;
`ifdef RE_ACC_SAT_EN
         ovf   <= 1'b0;
`endif
      end else if (clr) begin
         state <= IDLE;
         acc   <= '0;
         cnt   <= '0;
`ifdef RE_ACC_SAT_EN
         ovf   <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               // First beat loads rather than adds; it can never overflow.
               if (in_valid) begin
                  acc   <= {{(ACC_W - NL){1'b0}}, in_data};
                  cnt   <= 16'd1;
                  state <= (FL == 16'd1) ? OUT : ACC;
               end
            end
            ACC: begin
               if (in_valid) begin
`ifdef RE_ACC_SAT_EN
                  // Once clamped, stay clamped for the rest of the frame.
                  if (ovf || sum[ACC_W]) begin
                     acc <= '1;
                     ovf <= 1'b1;
                  end else begin
                     acc <= sum[ACC_W-1:0];
                  end
`else
                  acc <= sum[ACC_W-1:0];
`endif
                  cnt <= cnt_nxt;
                  if (cnt_nxt == FL) begin
                     state <= OUT;
                  end
               end
            end
            OUT: begin
               // No beat is taken on the handshake cycle; next frame
               // starts from IDLE.
               if (out_ready) begin
                  state <= IDLE;
                  acc   <= '0;
                  cnt   <= '0;
`ifdef RE_ACC_SAT_EN
                  ovf   <= 1'b0;
`endif
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_re_log_accum.sv
// tb_re_log_accum: directed vector bench for re_log_accum.
// Three instances share the input bus; each test resets and checks one.

module tb_re_log_accum;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_data;
   logic        clr;
   logic        out_ready;

   logic        a_ir, a_ov, a_ovf;
   logic [39:0] a_sum;
   logic        b_ir, b_ov, b_ovf;
   logic [32:0] b_sum;
   logic        c_ir, c_ov, c_ovf;
   logic [39:0] c_sum;

   int n_cmp = 0;
   int n_bad = 0;

   re_log_accum #(.FRAME_LEN(4), .ACC_W(40)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(a_ir), .clr(clr), .out_valid(a_ov),
      .out_ready(out_ready), .out_sum(a_sum), .out_ovf(a_ovf)
   );

   re_log_accum #(.FRAME_LEN(4), .ACC_W(33)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(b_ir), .clr(clr), .out_valid(b_ov),
      .out_ready(out_ready), .out_sum(b_sum), .out_ovf(b_ovf)
   );

   re_log_accum #(.FRAME_LEN(1), .ACC_W(40)) dut_c (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(c_ir), .clr(clr), .out_valid(c_ov),
      .out_ready(out_ready), .out_sum(c_sum), .out_ovf(c_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [31:0] d;
      logic        c;
      logic        ordy;
      logic        e_ir;
      logic        e_ov;
      logic [39:0] e_sum;
      logic        chk_sum;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic v, input logic [31:0] d,
                      input logic c, input logic ordy,
                      input logic e_ir, input logic e_ov,
                      input logic [39:0] e_sum, input logic chk_sum);
      vec_t r;
      r.v = v; r.d = d; r.c = c; r.ordy = ordy;
      r.e_ir = e_ir; r.e_ov = e_ov; r.e_sum = e_sum; r.chk_sum = chk_sum;
      tbl.push_back(r);
   endtask

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] d,
                        input logic c, input logic ordy);
      in_valid  = v;
      in_data   = d;
      clr       = c;
      out_ready = ordy;
   endtask

   task automatic do_reset();
      drive(1'b0, 32'd0, 1'b0, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      drive(1'b0, 32'd0, 1'b0, 1'b0);

      // Frame 1,2,3,4 back to back; one-cycle result.
      add(1, 1, 0, 1, 1, 0, 0, 0);
      add(1, 2, 0, 1, 1, 0, 0, 0);
      add(1, 3, 0, 1, 1, 0, 0, 0);
      add(1, 4, 0, 1, 0, 1, 10, 1);
      add(0, 0, 0, 1, 1, 0, 0, 1);
      // Frame 5,0,7,9 with gaps; result held under backpressure.
      add(1, 5, 0, 0, 1, 0, 0, 0);
      add(0, 0, 0, 0, 1, 0, 0, 0);
      add(0, 0, 0, 0, 1, 0, 0, 0);
      add(1, 0, 0, 0, 1, 0, 0, 0);
      add(0, 0, 0, 0, 1, 0, 0, 0);
      add(0, 0, 0, 0, 1, 0, 0, 0);
      add(1, 7, 0, 0, 1, 0, 0, 0);
      add(0, 0, 0, 0, 1, 0, 0, 0);
      add(0, 0, 0, 0, 1, 0, 0, 0);
      add(1, 9, 0, 0, 0, 1, 21, 1);
      for (int i = 0; i < 5; i++) add(1, 55, 0, 0, 0, 1, 21, 1);
      add(1, 55, 0, 1, 1, 0, 0, 1);
      add(0, 0, 0, 0, 1, 0, 0, 1);
      // Abort after two beats of 100, then a clean 1,1,1,1 frame.
      add(1, 100, 0, 0, 1, 0, 0, 0);
      add(1, 100, 0, 0, 1, 0, 0, 0);
      add(1, 100, 1, 0, 1, 0, 0, 1);
      add(1, 1, 0, 0, 1, 0, 0, 0);
      add(1, 1, 0, 0, 1, 0, 0, 0);
      add(1, 1, 0, 0, 1, 0, 0, 0);
      add(1, 1, 0, 0, 0, 1, 4, 1);
      add(0, 0, 0, 1, 1, 0, 0, 1);

      // Reset state, checked while rst is high.
      rst = 1'b1;
      #1;
      chk("rst_ir", 64'(a_ir), 64'd1);
      chk("rst_ov", 64'(a_ov), 64'd0);
      chk("rst_sum", 64'(a_sum), 64'd0);
      chk("rst_ovf", 64'(a_ovf), 64'd0);
      step();
      rst = 1'b0;

      foreach (tbl[i]) begin
         drive(tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].ordy);
         step();
         chk($sformatf("v%0d_ir", i), 64'(a_ir), 64'(tbl[i].e_ir));
         chk($sformatf("v%0d_ov", i), 64'(a_ov), 64'(tbl[i].e_ov));
         if (tbl[i].chk_sum) begin
            chk($sformatf("v%0d_sum", i), 64'(a_sum), 64'(tbl[i].e_sum));
            chk($sformatf("v%0d_ovf", i), 64'(a_ovf), 64'd0);
         end
      end

      // ACC_W=33 overflow: four beats of 0xFFFFFFFF.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
         step();
      end
      drive(1'b0, 32'd0, 1'b0, 1'b0);
      chk("ovf_valid", 64'(b_ov), 64'd1);
`ifdef RE_ACC_SAT_EN
      chk("ovf_sum", 64'(b_sum), 64'h1_FFFF_FFFF);
      chk("ovf_flag", 64'(b_ovf), 64'd1);
`else
      chk("ovf_sum", 64'(b_sum), 64'h1_FFFF_FFFC);
      chk("ovf_flag", 64'(b_ovf), 64'd0);
`endif
      out_ready = 1'b1;
      step();
      chk("ovf_clear", 64'(b_ovf), 64'd0);
      chk("ovf_idle", 64'(b_ir), 64'd1);

      // Asynchronous reset between edges after beat 3 of 4.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'd3, 1'b0, 1'b0);
         step();
      end
      drive(1'b0, 32'd0, 1'b0, 1'b0);
      #1;
      rst = 1'b1;
      #1;
      chk("arst_sum", 64'(a_sum), 64'd0);
      chk("arst_ir", 64'(a_ir), 64'd1);
      chk("arst_ov", 64'(a_ov), 64'd0);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'd2, 1'b0, 1'b0);
         step();
      end
      drive(1'b0, 32'd0, 1'b0, 1'b0);
      chk("arst_fv", 64'(a_ov), 64'd1);
      chk("arst_fsum", 64'(a_sum), 64'd8);

      // FRAME_LEN=1: continuous beats, one per two cycles.
      do_reset();
      drive(1'b1, 32'd7, 1'b0, 1'b1);
      step();
      chk("f1_ov0", 64'(c_ov), 64'd1);
      chk("f1_sum0", 64'(c_sum), 64'd7);
      chk("f1_ir0", 64'(c_ir), 64'd0);
      in_data = 32'd9;
      step();
      chk("f1_idle", 64'(c_ov), 64'd0);
      chk("f1_ir1", 64'(c_ir), 64'd1);
      step();
      chk("f1_ov1", 64'(c_ov), 64'd1);
      chk("f1_sum1", 64'(c_sum), 64'd9);
      drive(1'b0, 32'd0, 1'b0, 1'b1);
      step();
      chk("f1_done", 64'(c_ov), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
